// File: rtl/systolic_result_drain.sv
// Snapshots the 8x8 systolic array results once the feeder has finished and the array has settled,
// clears the array accumulators, then streams the captured matrix out one row per valid/ready beat.
`timescale 1ns/1ps
module systolic_result_drain #(
  parameter int N             = 8,
  parameter int ACC_WIDTH     = 32,
  parameter int OUT_WIDTH     = 16,
  parameter int OUT_SHIFT     = 0,
  parameter int SETTLE_CYCLES = 19
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       feed_done,
  input  logic [N*N*ACC_WIDTH-1:0]   c_out_flat,
  output logic                       array_clr,
  output logic [N*OUT_WIDTH-1:0]     out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [$clog2(N)-1:0]       out_row,
  output logic                       busy,
  output logic                       overrun
);

  localparam int RW = $clog2(N);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int WW = ACC_WIDTH + OUT_WIDTH;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] LAST_ROW    = RW'(N - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           settle_cnt, settle_cnt_nxt;
  logic [RW-1:0]           row_cnt, row_cnt_nxt;
  logic [N*N*ACC_WIDTH-1:0] snapshot;
  logic [N*ACC_WIDTH-1:0]  row_sel;

  // Shift then clamp to the largest representable output value instead of wrapping.
  function automatic logic [OUT_WIDTH-1:0] scale_sat(input logic [ACC_WIDTH-1:0] e);
    logic [WW-1:0] v;
    v = WW'(e >> OUT_SHIFT);
    if (v > WW'({OUT_WIDTH{1'b1}})) return {OUT_WIDTH{1'b1}};
    return v[OUT_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      row_cnt    <= '0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
      row_cnt    <= row_cnt_nxt;
      if (feed_done && (state != IDLE)) overrun <= 1'b1;
    end
  end

  // The snapshot decouples streamed data from whatever the array does after the clear.
  always_ff @(posedge clk) begin
    if (rst) snapshot <= '0;
    else if (state == CAPTURE) snapshot <= c_out_flat;
  end

  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    row_cnt_nxt    = row_cnt;
    array_clr      = 1'b0;
    out_valid      = 1'b0;
    case (state)
      IDLE: begin
        if (feed_done) begin
          state_nxt      = SETTLE;
          settle_cnt_nxt = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (en) begin
          if (settle_cnt == '0) state_nxt = CAPTURE;
          else settle_cnt_nxt = settle_cnt - CW'(1);
        end
      end
      CAPTURE: begin
        array_clr   = 1'b1;
        row_cnt_nxt = '0;
        state_nxt   = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (row_cnt == LAST_ROW) begin
            row_cnt_nxt = '0;
            state_nxt   = IDLE;
          end else begin
            row_cnt_nxt = row_cnt + RW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign row_sel = snapshot[int'(row_cnt) * (N*ACC_WIDTH) +: N*ACC_WIDTH];

  always_comb begin
    out_data = '0;
    if (state == DRAIN) begin
      for (int j = 0; j < N; j++) begin
        out_data[j*OUT_WIDTH +: OUT_WIDTH] = scale_sat(row_sel[j*ACC_WIDTH +: ACC_WIDTH]);
      end
    end
  end

  assign out_row  = (state == DRAIN) ? row_cnt : '0;
  assign out_last = (state == DRAIN) && (row_cnt == LAST_ROW);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain: expected rows are queued when a matrix is issued and
// monitors compare every beat the DUTs present (a second instance exercises OUT_SHIFT=4).
`timescale 1ns/1ps
module tb_systolic_result_drain;
  localparam int N  = 8;
  localparam int AW = 32;
  localparam int OW = 16;
  localparam int RW = 3;

  typedef struct packed {
    logic [N*OW-1:0] data;
    logic [RW-1:0]   row;
    logic            last;
  } beat_t;

  logic clk = 1'b0;
  logic rst, en, feed_done, feed_done4, out_ready;
  logic [N*N*AW-1:0] c_out_flat;
  logic array_clr, out_valid, out_last, busy, overrun;
  logic [N*OW-1:0] out_data;
  logic [RW-1:0] out_row;
  logic array_clr4, out_valid4, out_last4, busy4, overrun4;
  logic [N*OW-1:0] out_data4;
  logic [RW-1:0] out_row4;

  beat_t q0[$];
  beat_t q4[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int hs0      = 0;
  int unsigned mat [N][N];

  systolic_result_drain dut (
    .clk(clk), .rst(rst), .en(en), .feed_done(feed_done), .c_out_flat(c_out_flat),
    .array_clr(array_clr), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_row(out_row), .busy(busy), .overrun(overrun)
  );

  systolic_result_drain #(.OUT_SHIFT(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .feed_done(feed_done4), .c_out_flat(c_out_flat),
    .array_clr(array_clr4), .out_data(out_data4), .out_valid(out_valid4), .out_ready(1'b1),
    .out_last(out_last4), .out_row(out_row4), .busy(busy4), .overrun(overrun4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [OW-1:0] sat(input int unsigned e, input int sh);
    int unsigned v;
    v = e >> sh;
    if (v > 32'd65535) return 16'hFFFF;
    return v[15:0];
  endfunction

  function automatic beat_t modelRow(input int i, input int sh);
    beat_t b;
    b.data = '0;
    for (int j = 0; j < N; j++) b.data[j*OW +: OW] = sat(mat[i][j], sh);
    b.row  = RW'(i);
    b.last = (i == N-1);
    return b;
  endfunction

  // Loads mat onto c_out_flat, queues expected rows, pulses feed_done for one cycle.
  task automatic applyStimulus(input bit also4, output int k);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        c_out_flat[(i*N+j)*AW +: AW] = mat[i][j];
    for (int i = 0; i < N; i++) begin
      q0.push_back(modelRow(i, 0));
      if (also4) q4.push_back(modelRow(i, 4));
    end
    k = cyc;
    feed_done  = 1'b1;
    feed_done4 = also4;
    @(posedge clk); #1;
    feed_done  = 1'b0;
    feed_done4 = 1'b0;
  endtask

  task automatic waitValid(input int limit, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < limit; t++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic waitIdle(input string name, input int limit);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < limit; t++) begin
      @(posedge clk); #1;
      if (!busy && !busy4) begin ok = 1'b1; break; end
    end
    checkOutput({name, "_idle"}, ok, 1'b1);
    checkOutput({name, "_q_empty"}, q0.size() + q4.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q0.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL unexpected_beat: got valid row %0d, expected no beat", out_row);
      end else begin
        checkOutput($sformatf("row%0d_data", q0[0].row), out_data, q0[0].data);
        checkOutput($sformatf("row%0d_idx", q0[0].row), out_row, q0[0].row);
        checkOutput($sformatf("row%0d_last", q0[0].row), out_last, q0[0].last);
        if (out_ready) begin
          void'(q0.pop_front());
          hs0++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid4) begin
      if (q4.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL unexpected_beat4: got valid row %0d, expected no beat", out_row4);
      end else begin
        checkOutput($sformatf("sh4_row%0d_data", q4[0].row), out_data4, q4[0].data);
        checkOutput($sformatf("sh4_row%0d_idx", q4[0].row), out_row4, q4[0].row);
        checkOutput($sformatf("sh4_row%0d_last", q4[0].row), out_last4, q4[0].last);
        void'(q4.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int first_off;
    bit ok;
    beat_t b;
    logic [5:0] pat;
    int unsigned h_elem [N];
    logic [OW-1:0] h_exp0 [N];
    logic [OW-1:0] h_exp4 [N];

    rst = 1'b1; en = 1'b1; feed_done = 1'b0; feed_done4 = 1'b0; out_ready = 1'b1;
    c_out_flat = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_array_clr", array_clr, 1'b0);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_last", out_last, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_overrun", overrun, 1'b0);
    checkOutput("rst_out_data", out_data, '0);
    checkOutput("rst_out_row", out_row, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full drain of C = A*B with cycle-exact timing
    $display("[TB] full drain");
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        mat[i][j] = 0;
        for (int kk = 0; kk < N; kk++)
          mat[i][j] += (8*i + kk + 1) * (64 - (8*kk + j));
      end
    applyStimulus(1'b1, k);
    for (int j = 0; j < N; j++) begin
      b = q0[0]; b.data[j*OW +: OW] = OW'(960 - 36*j); q0[0] = b;
      b = q0[7]; b.data[j*OW +: OW] = OW'(17088 - 484*j); q0[7] = b;
      b = q4[7]; b.data[j*OW +: OW] = OW'((17088 - 484*j) >> 4); q4[7] = b;
    end
    repeat (29) begin
      @(negedge clk);
      checkOutput($sformatf("t%0d_array_clr", cyc-k), array_clr, (cyc-k) == 20);
      checkOutput($sformatf("t%0d_out_valid", cyc-k), out_valid, (cyc-k) >= 21 && (cyc-k) <= 28);
      checkOutput($sformatf("t%0d_busy", cyc-k), busy, (cyc-k) <= 28);
    end
    waitIdle("full", 10);

    // Backpressure with ready pattern 1,0,0,1,0,1
    $display("[TB] backpressure");
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mat[i][j] = 1000*i + 7*j + 5;
    out_ready = 1'b0;
    hs0 = 0;
    applyStimulus(1'b0, k);
    waitValid(40, ok);
    checkOutput("bp_first_valid", ok, 1'b1);
    @(posedge clk); #1;
    pat = 6'b101001;
    ok = 1'b0;
    for (int t = 0; t < 80; t++) begin
      out_ready = pat[t % 6];
      @(posedge clk); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
    out_ready = 1'b1;
    checkOutput("bp_complete", ok, 1'b1);
    checkOutput("bp_handshakes", hs0, 8);
    waitIdle("bp", 10);

    // Saturation and shift on hand-picked elements in row 0
    $display("[TB] width");
    h_elem = '{70000, 13700, 65535, 65536, 0, 1048575, 1048576, 15};
    h_exp0 = '{16'd65535, 16'd13700, 16'd65535, 16'd65535, 16'd0, 16'd65535, 16'd65535, 16'd15};
    h_exp4 = '{16'd4375, 16'd856, 16'd4095, 16'd4096, 16'd0, 16'd65535, 16'd65535, 16'd0};
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mat[i][j] = (i == 0) ? h_elem[j] : 70000*i + 5000*j;
    applyStimulus(1'b1, k);
    b = q0[0];
    for (int j = 0; j < N; j++) b.data[j*OW +: OW] = h_exp0[j];
    q0[0] = b;
    b = q4[0];
    for (int j = 0; j < N; j++) b.data[j*OW +: OW] = h_exp4[j];
    q4[0] = b;
    waitIdle("width", 40);

    // Overrun during DRAIN plus input change after capture
    $display("[TB] overrun and isolation");
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mat[i][j] = 8*i + j + 100;
    out_ready = 1'b0;
    applyStimulus(1'b0, k);
    waitValid(40, ok);
    checkOutput("ov_first_valid", ok, 1'b1);
    @(posedge clk); #1;
    c_out_flat = '1;
    feed_done = 1'b1;
    @(posedge clk); #1;
    feed_done = 1'b0;
    out_ready = 1'b1;
    waitIdle("ov", 20);
    checkOutput("ov_overrun_set", overrun, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    checkOutput("ov_no_redrain_busy", busy, 1'b0);
    checkOutput("ov_no_redrain_valid", out_valid, 1'b0);
    checkOutput("ov_overrun_sticky", overrun, 1'b1);

    // Reset after 3 handshakes, then restart with en stalls in SETTLE
    $display("[TB] reset and enable");
    hs0 = 0;
    applyStimulus(1'b0, k);
    ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(posedge clk); #1;
      if (hs0 >= 3) begin ok = 1'b1; break; end
    end
    checkOutput("rs_three_handshakes", ok, 1'b1);
    rst = 1'b1;
    q0.delete();
    @(posedge clk); #1;
    checkOutput("rs_out_valid", out_valid, 1'b0);
    checkOutput("rs_busy", busy, 1'b0);
    checkOutput("rs_overrun_cleared", overrun, 1'b0);
    checkOutput("rs_array_clr", array_clr, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b0, k);
    repeat (3) @(posedge clk);
    #1;
    en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    en = 1'b1;
    first_off = -1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (out_valid) begin first_off = cyc - k; break; end
    end
    checkOutput("en_first_valid_cycle", first_off, 26);
    waitIdle("en", 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
